// File: rtl/neopixel_rx_pkg.sv
// +------------------------------------------------------------------+
// | Module   : neopixel_rx_pkg                                       |
// | Purpose  : Shared WS2812 timing constants and receiver state     |
// |            encoding for the NeoPixel transmitter/receiver pair.  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
`default_nettype none

package neopixel_rx_pkg;

   // Nominal WS2812 bit timing at 27 MHz, in clock cycles
   localparam int c_t0h              = 8;
   localparam int c_t0l              = 26;
   localparam int c_t1h              = 16;
   localparam int c_t1l              = 18;
   localparam int c_treset           = 1350;
   localparam int c_bits_per_pixel   = 24;

   // Receiver states
   typedef enum logic [1:0] {
      S_SYNC = 2'd0,   // waiting for a reset gap before trusting the line
      S_IDLE = 2'd1,   // between frames, line low
      S_HIGH = 2'd2,   // measuring a HIGH pulse
      S_LOW  = 2'd3    // measuring the LOW gap after a bit
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/neopixel_rx_sync.sv
// +------------------------------------------------------------------+
// | Module   : neopixel_rx_sync                                      |
// | Purpose  : Two-flop synchronizer for the serial line with        |
// |            single-cycle rise/fall pulses.                        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
`default_nettype none

module neopixel_rx_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_din,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Two synchronizer stages plus one history stage for edge detection
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_din;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/neopixel_rx.sv
// +------------------------------------------------------------------+
// | Module   : neopixel_rx                                           |
// | Purpose  : WS2812 one-wire receiver. Classifies HIGH pulse       |
// |            widths into bits, assembles 24-bit MSB-first pixels   |
// |            and writes them to pixel RAM; flags protocol errors.  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
`default_nettype none

module neopixel_rx
   import neopixel_rx_pkg::*;
#(
   parameter int NUM_PIXELS    = 8,
   parameter int BIT_THRESH    = 12,
   parameter int MIN_HIGH      = 3,
   parameter int MAX_HIGH      = 32,
   parameter int TRESET_CYCLES = c_treset
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_din,
   output logic [7:0]  o_mem_addr,
   output logic [23:0] o_mem_data,
   output logic        o_mem_we,
   output logic        o_frame_done,
   output logic [7:0]  o_pixel_count,
   output logic        o_err
);

   // The counter is cleared in the first cycle of a new level, so a run of
   // N cycles shows N-1 in the cycle the closing edge is seen and N-2 in the
   // N-th cycle of the run itself. Thresholds are pre-shifted accordingly.
   localparam logic [15:0] c_thresh_cnt = 16'(BIT_THRESH - 1);
   localparam logic [15:0] c_min_cnt    = 16'(MIN_HIGH - 1);
   localparam logic [15:0] c_max_cnt    = 16'(MAX_HIGH - 1);
   localparam logic [15:0] c_low_term   = 16'(TRESET_CYCLES - 2);
   localparam logic [4:0]  c_last_bit   = 5'(c_bits_per_pixel - 1);
   localparam logic [8:0]  c_num_px     = 9'(NUM_PIXELS);

   logic        w_level;
   logic        w_rise;
   logic        w_fall;

   rx_state_t   r_state;
   rx_state_t   w_state_nxt;
   logic        w_shift_en;
   logic        w_bit;
   logic        w_err_fsm;
   logic        w_frame_end;
   logic        w_clear_idx;

   logic [15:0] r_cnt;
   logic [22:0] r_shift;
   logic [4:0]  r_bit_idx;
   logic [23:0] r_word;
   logic        r_pix_done;
   logic [7:0]  r_pix_idx;

   neopixel_rx_sync u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_din   (i_din),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and per-cycle decode strobes
   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_bit       = 1'b0;
      w_err_fsm   = 1'b0;
      w_frame_end = 1'b0;
      w_clear_idx = 1'b0;
      case (r_state)
         S_SYNC: begin
            w_clear_idx = 1'b1;
            if (!w_level && (r_cnt >= c_low_term)) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            w_clear_idx = 1'b1;
            if (w_rise) begin
               w_state_nxt = S_HIGH;
            end
         end
         S_HIGH: begin
            if (w_fall) begin
               if ((r_cnt < c_min_cnt) || (r_cnt > c_max_cnt)) begin
                  w_err_fsm   = 1'b1;
                  w_state_nxt = S_SYNC;
               end else begin
                  w_shift_en  = 1'b1;
                  w_bit       = (r_cnt >= c_thresh_cnt);
                  w_state_nxt = S_LOW;
               end
            end else if (r_cnt >= c_max_cnt) begin
               // Line has been high for MAX_HIGH+1 cycles: stuck high
               w_err_fsm   = 1'b1;
               w_state_nxt = S_SYNC;
            end
         end
         S_LOW: begin
            if (w_rise) begin
               w_state_nxt = S_HIGH;
            end else if (r_cnt >= c_low_term) begin
               w_frame_end = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_SYNC;
         end
      endcase
   end

   // Width counter, bit assembly, pixel write stage and status pulses
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt         <= '0;
         r_shift       <= '0;
         r_bit_idx     <= '0;
         r_word        <= '0;
         r_pix_done    <= 1'b0;
         r_pix_idx     <= '0;
         o_mem_addr    <= '0;
         o_mem_data    <= '0;
         o_mem_we      <= 1'b0;
         o_frame_done  <= 1'b0;
         o_pixel_count <= '0;
         o_err         <= 1'b0;
      end else begin
         o_mem_we     <= 1'b0;
         o_frame_done <= 1'b0;
         o_err        <= w_err_fsm;
         r_pix_done   <= 1'b0;

         if (w_rise || w_fall) begin
            r_cnt <= '0;
         end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
         end

         if (w_shift_en) begin
            if (r_bit_idx == c_last_bit) begin
               r_word     <= {r_shift, w_bit};
               r_pix_done <= 1'b1;
               r_shift    <= '0;
               r_bit_idx  <= '0;
            end else begin
               r_shift    <= {r_shift[21:0], w_bit};
               r_bit_idx  <= r_bit_idx + 5'd1;
            end
         end

         // Pixels beyond RAM depth are counted but dropped with an error
         if (r_pix_done) begin
            if ({1'b0, r_pix_idx} < c_num_px) begin
               o_mem_we   <= 1'b1;
               o_mem_addr <= r_pix_idx;
               o_mem_data <= r_word;
            end else begin
               o_err <= 1'b1;
            end
            if (r_pix_idx != 8'hFF) begin
               r_pix_idx <= r_pix_idx + 8'd1;
            end
         end

         // A partial pixel at frame end is discarded and flagged
         if (w_frame_end) begin
            o_frame_done  <= 1'b1;
            o_pixel_count <= r_pix_idx;
            if (r_bit_idx != 5'd0) begin
               o_err <= 1'b1;
            end
         end

         if (w_clear_idx) begin
            r_pix_idx <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_neopixel_rx.sv
// +------------------------------------------------------------------+
// | Module   : tb_neopixel_rx                                        |
// | Purpose  : Randomized scoreboard bench for neopixel_rx.          |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
`default_nettype none

module tb_neopixel_rx;

   localparam int NUM_PIX = 8;
   localparam int TRESET  = 1350;

   logic        i_clk;
   logic        i_reset;
   logic        i_din;
   logic [7:0]  o_mem_addr;
   logic [23:0] o_mem_data;
   logic        o_mem_we;
   logic        o_frame_done;
   logic [7:0]  o_pixel_count;
   logic        o_err;

   typedef struct packed {
      logic [7:0]  addr;
      logic [23:0] data;
   } wr_t;

   typedef struct packed {
      logic [7:0] count;
      logic       partial;
   } fd_t;

   wr_t         wq[$];
   fd_t         fq[$];
   logic [23:0] frame_words[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          err_exp  = 0;
   int          err_seen = 0;

   neopixel_rx #(
      .NUM_PIXELS    (NUM_PIX),
      .BIT_THRESH    (12),
      .MIN_HIGH      (3),
      .MAX_HIGH      (32),
      .TRESET_CYCLES (TRESET)
   ) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_din         (i_din),
      .o_mem_addr    (o_mem_addr),
      .o_mem_data    (o_mem_data),
      .o_mem_we      (o_mem_we),
      .o_frame_done  (o_frame_done),
      .o_pixel_count (o_pixel_count),
      .o_err         (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an output
   always @(negedge i_clk) begin
      wr_t ew;
      fd_t ef;
      if (o_mem_we) begin
         if (wq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data 0x%06h, no write required", o_mem_addr, o_mem_data);
         end else begin
            ew = wq.pop_front();
            check("write_addr", 32'(o_mem_addr), 32'(ew.addr));
            check("write_data", 32'(o_mem_data), 32'(ew.data));
         end
      end
      if (o_frame_done) begin
         if (fq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame_done: count %0d, no frame end required", o_pixel_count);
         end else begin
            ef = fq.pop_front();
            check("frame_pixel_count", 32'(o_pixel_count), 32'(ef.count));
            check("frame_partial_err", 32'(o_err), 32'(ef.partial));
         end
      end
      if (o_mem_we && o_frame_done) begin
         n_checks++;
         n_fail++;
         $display("FAIL write_and_frame_done: both strobes high together");
      end
      if (o_err) err_seen++;
   end

   // Line timing generators: mode 0 random legal, 1 nominal, 2 threshold edges
   function automatic int hi_width(input logic b, input int mode, input int i);
      if (mode == 1) return b ? 16 : 8;
      if (mode == 2) return b ? ((i % 2 == 1) ? 12 : 32) : ((i % 2 == 1) ? 11 : 3);
      return b ? int'($urandom_range(32, 12)) : int'($urandom_range(11, 3));
   endfunction

   function automatic int lo_width(input logic b, input int mode);
      if (mode == 1) return b ? 18 : 26;
      return int'($urandom_range(12, 4));
   endfunction

   task automatic send_pulse(input int hi, input int lo);
      i_din = 1'b1;
      repeat (hi) @(negedge i_clk);
      i_din = 1'b0;
      repeat (lo) @(negedge i_clk);
   endtask

   task automatic send_bits(input logic [23:0] w, input int nbits, input int mode, input int last_low);
      for (int i = 0; i < nbits; i++) begin
         logic b;
         b = w[23 - i];
         send_pulse(hi_width(b, mode, i), (i == nbits - 1) ? last_low : lo_width(b, mode));
      end
   endtask

   task automatic random_frame(input int n);
      frame_words.delete();
      for (int k = 0; k < n; k++) frame_words.push_back(24'($urandom));
   endtask

   // Reference model: the first NUM_PIX words land at addresses 0.., the
   // rest each cost one error; the frame reports every complete pixel.
   task automatic send_frame(input int mode, input int gap, input int long_px);
      int n;
      n = frame_words.size();
      for (int k = 0; k < n; k++) begin
         if (k < NUM_PIX) wq.push_back('{addr: 8'(k), data: frame_words[k]});
         else err_exp++;
      end
      fq.push_back('{count: (n > 255) ? 8'd255 : 8'(n), partial: 1'b0});
      for (int k = 0; k < n; k++) begin
         send_bits(frame_words[k], 24, mode,
                   (k == n - 1) ? gap : ((k == long_px) ? TRESET - 1 : lo_width(1'b0, mode)));
      end
   endtask

   task automatic settle(input string name);
      repeat (8) @(negedge i_clk);
      #1;
      check({name, "_writes_pending"}, 32'(wq.size()), 32'd0);
      check({name, "_frames_pending"}, 32'(fq.size()), 32'd0);
      check({name, "_err_pulses"}, 32'(err_seen), 32'(err_exp));
   endtask

   initial begin
      repeat (90000) @(posedge i_clk);
      $display("FAIL watchdog: run exceeded 90000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [23:0] w0;
      logic [23:0] w1;

      // Reset state
      i_reset = 1'b1;
      i_din   = 1'b0;
      repeat (3) @(negedge i_clk);
      check("reset_mem_we", 32'(o_mem_we), 32'd0);
      check("reset_mem_addr", 32'(o_mem_addr), 32'd0);
      check("reset_mem_data", 32'(o_mem_data), 32'd0);
      check("reset_frame_done", 32'(o_frame_done), 32'd0);
      check("reset_pixel_count", 32'(o_pixel_count), 32'd0);
      check("reset_err", 32'(o_err), 32'd0);

      // Power-up mid-stream: nothing decoded until the first reset gap
      send_bits(24'($urandom), 13, 0, 6);
      i_reset = 1'b0;
      send_bits(24'($urandom), 11, 0, 7);
      send_bits(24'($urandom), 24, 0, 9);
      send_bits(24'($urandom), 24, 0, TRESET + 50);
      settle("powerup");

      // Loopback-style frame with nominal timing
      frame_words.delete();
      frame_words.push_back(24'h000001);
      frame_words.push_back(24'h0000FF);
      frame_words.push_back(24'h00FF00);
      frame_words.push_back(24'hFF0000);
      frame_words.push_back(24'hFFFFFF);
      frame_words.push_back(24'h123456);
      frame_words.push_back(24'hABCDEF);
      frame_words.push_back(24'hFF00FF);
      send_frame(1, TRESET + 50, -1);
      settle("loopback");

      // Random frames back to back, separated by exactly TRESET low cycles
      random_frame(int'($urandom_range(10, 1)));
      send_frame(0, TRESET, -1);
      random_frame(int'($urandom_range(10, 1)));
      send_frame(0, TRESET, -1);
      random_frame(int'($urandom_range(10, 1)));
      send_frame(0, TRESET + 50, -1);
      settle("random");

      // Widths 3, 11, 12, 32 all accepted with the right bit value
      random_frame(2);
      send_frame(2, TRESET + 50, -1);
      settle("width_edges");

      // Overflow: 10 pixels into 8 slots
      random_frame(10);
      send_frame(0, TRESET + 50, -1);
      settle("overflow");

      // Glitch (2 cycles) and stuck-high (33 cycles) each abort the frame
      send_bits(24'($urandom), 5, 0, 6);
      err_exp++;
      send_pulse(2, TRESET + 50);
      settle("glitch");
      send_bits(24'($urandom), 3, 0, 6);
      err_exp++;
      send_pulse(33, TRESET + 50);
      settle("stuck_high");
      random_frame(1);
      send_frame(0, TRESET + 50, -1);
      settle("after_errors");

      // Partial pixel: 30 bits then a reset gap
      w0 = 24'($urandom);
      w1 = 24'($urandom);
      wq.push_back('{addr: 8'd0, data: w0});
      fq.push_back('{count: 8'd1, partial: 1'b1});
      err_exp++;
      send_bits(w0, 24, 0, 5);
      send_bits(w1, 6, 0, TRESET + 50);
      settle("partial");

      // A LOW run one short of the reset gap keeps the frame going
      random_frame(2);
      send_frame(0, TRESET + 50, 0);
      settle("gap_1349");

      // Reset mid-pixel: no writes until the line is resynchronized
      send_bits(24'($urandom), 10, 0, 5);
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      check("midreset_pixel_count", 32'(o_pixel_count), 32'd0);
      send_bits(24'($urandom), 14, 0, 8);
      send_bits(24'($urandom), 24, 0, TRESET + 50);
      settle("mid_reset");
      random_frame(2);
      send_frame(0, TRESET + 50, -1);
      settle("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
